// File: rtl/ps_alu_ctrl_if.sv
// Sequencer <-> ALU-controller bundle: instruction issue, ALU control fields,
// returned ALU flags and the resulting status.
interface ps_alu_ctrl_if #(
  parameter int CACC_WIDTH = 8
);
  logic [31:0]           ps_instr;
  logic                  ps_instr_vld;
  logic                  ps_mode_sat;
  logic                  ps_astat_clr;
  logic                  alu_ps_az;
  logic                  alu_ps_an;
  logic                  alu_ps_ac;
  logic                  alu_ps_av;
  logic                  alu_ps_compd;
  logic                  ps_alu_en;
  logic                  ps_alu_log;
  logic [1:0]            ps_alu_hc;
  logic [2:0]            ps_alu_sc;
  logic                  ps_alu_sat;
  logic                  ps_alu_ci;
  logic                  ps_instr_stall;
  logic [4:0]            ps_astat;
  logic [CACC_WIDTH-1:0] ps_cacc;
  logic                  ps_cond_true;

  // Environment side: sequencer plus ALU flag return.
  modport master (
    output ps_instr, ps_instr_vld, ps_mode_sat, ps_astat_clr,
           alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd,
    input  ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci,
           ps_instr_stall, ps_astat, ps_cacc, ps_cond_true
  );

  // Controller side.
  modport slave (
    input  ps_instr, ps_instr_vld, ps_mode_sat, ps_astat_clr,
           alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd,
    output ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci,
           ps_instr_stall, ps_astat, ps_cacc, ps_cond_true
  );
endinterface

// File: rtl/ps_alu_ctrl.sv
// ALU controller on the program-sequencer side: decodes ALU compute
// instructions, drives registered ALU controls, folds returned flags into
// ASTAT/CACC, evaluates condition codes and stalls on in-flight flags.
module ps_alu_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CACC_WIDTH = 8
) (
  input  logic          clk_exe,
  input  logic          reset,
  ps_alu_ctrl_if.slave  bus
);
  // The datapath width only matters to the ALU; control is width-agnostic.
  localparam int unused_data_width = DATA_WIDTH;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] unit;
  logic       lg;
  logic [1:0] hc;
  logic [2:0] sc;
  logic       unused_instr;

  assign cond = bus.ps_instr[31:28];
  assign unit = bus.ps_instr[25:24];
  assign lg   = bus.ps_instr[22];
  assign hc   = bus.ps_instr[21:20];
  assign sc   = bus.ps_instr[19:17];
  assign unused_instr = ^{bus.ps_instr[27:26], bus.ps_instr[23], bus.ps_instr[16:0]};

  // Status state: astat = {AVS, AV, AC, AN, AZ}
  logic [4:0]            astat;
  logic [CACC_WIDTH-1:0] cacc;
  logic                  s1, s2;

  logic cond_true, flag_dep, stall, accept, issue, gt;
  logic [CACC_WIDTH-2:0] cacc_tail;

  // Condition-code evaluation against the committed ASTAT/CACC only.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = astat[0];
      4'h2: cond_true = ~astat[0];
      4'h3: cond_true = astat[1];
      4'h4: cond_true = ~astat[1];
      4'h5: cond_true = astat[1] | astat[0];
      4'h6: cond_true = ~astat[1] & ~astat[0];
      4'h7: cond_true = astat[2];
      4'h8: cond_true = ~astat[2];
      4'h9: cond_true = astat[3];
      4'hA: cond_true = ~astat[3];
      4'hB: cond_true = cacc[CACC_WIDTH-1];
      default: cond_true = 1'b0;
    endcase
  end

  // Conditional instructions and carry-in ops need settled flags.
  assign flag_dep = (cond != 4'h0) | (~lg & (hc == 2'b00) & (sc[2:1] == 2'b01));
  assign stall    = bus.ps_instr_vld & flag_dep & (s1 | s2);
  assign accept   = bus.ps_instr_vld & ~stall;
  assign issue    = accept & (unit == 2'b00) & cond_true;

  // New compare result (rx > ry) and the shifted-down history behind it.
  assign gt        = ~bus.alu_ps_an & ~bus.alu_ps_az;
  assign cacc_tail = bus.ps_astat_clr ? '0 : cacc[CACC_WIDTH-1:1];

  // Issue register: strobe pulses per issue, fields hold the last issue.
  always_ff @(posedge clk_exe or posedge reset) begin
    if (reset) begin
      bus.ps_alu_en  <= 1'b0;
      bus.ps_alu_log <= 1'b0;
      bus.ps_alu_hc  <= 2'b00;
      bus.ps_alu_sc  <= 3'b000;
      bus.ps_alu_sat <= 1'b0;
      bus.ps_alu_ci  <= 1'b0;
    end else begin
      bus.ps_alu_en <= issue;
      if (issue) begin
        bus.ps_alu_log <= lg;
        bus.ps_alu_hc  <= hc;
        bus.ps_alu_sc  <= sc;
        bus.ps_alu_sat <= bus.ps_mode_sat;
        bus.ps_alu_ci  <= astat[2];
      end
    end
  end

  // In-flight tracker: s1 = ALU latching this op, s2 = flags on the bus.
  always_ff @(posedge clk_exe or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= issue;
      s2 <= s1;
    end
  end

  // Flag capture at the end of s2; sticky AVS and CACC share the clear,
  // with a same-cycle capture taking priority.
  always_ff @(posedge clk_exe or posedge reset) begin
    if (reset) begin
      astat <= 5'b0;
      cacc  <= '0;
    end else begin
      if (s2)
        astat[3:0] <= {bus.alu_ps_av, bus.alu_ps_ac, bus.alu_ps_an, bus.alu_ps_az};
      astat[4] <= (astat[4] & ~bus.ps_astat_clr) | (s2 & bus.alu_ps_av);
      if (s2 & bus.alu_ps_compd)
        cacc <= {gt, cacc_tail};
      else if (bus.ps_astat_clr)
        cacc <= '0;
    end
  end

  assign bus.ps_instr_stall = stall;
  assign bus.ps_cond_true   = cond_true;
  assign bus.ps_astat       = astat;
  assign bus.ps_cacc        = cacc;
endmodule

// File: tb/tb_ps_alu_ctrl.sv
// Bench for ps_alu_ctrl: directed instruction vectors with hand-computed
// ALU controls and ASTAT/CACC, checked by a scoreboard monitor.
module tb_ps_alu_ctrl;
  logic clk_exe = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk_exe = ~clk_exe;

  ps_alu_ctrl_if #(.CACC_WIDTH(8)) bus ();
  ps_alu_ctrl #(.DATA_WIDTH(16), .CACC_WIDTH(8)) alu (
    .clk_exe (clk_exe),
    .reset   (reset),
    .bus     (bus)
  );

  // Scoreboard queues: controls at issue, {astat, cacc} two edges later,
  // operands for the ALU model.
  logic [7:0]  ctrl_q[$];
  logic [12:0] stat_q[$];
  logic [31:0] op_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ALU model: latches operands/controls when ps_alu_en is seen, then
  // presents flags combinationally for the following cycle.
  logic [15:0] ax = '0, ay = '0, alu_res;
  logic [7:0]  a_ctl = '0;
  logic        a_v = 1'b0;
  always @(posedge clk_exe) begin
    a_v <= bus.ps_alu_en;
    if (bus.ps_alu_en) begin
      a_ctl <= {bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc, bus.ps_alu_sat, bus.ps_alu_ci};
      if (op_q.size() != 0) {ax, ay} <= op_q.pop_front();
    end
  end

  logic [16:0] sum;
  logic        ov;
  always_comb begin
    bus.alu_ps_az = 1'b0; bus.alu_ps_an = 1'b0; bus.alu_ps_ac = 1'b0;
    bus.alu_ps_av = 1'b0; bus.alu_ps_compd = 1'b0;
    sum = '0; ov = 1'b0; alu_res = '0;
    if (a_v) begin
      if (a_ctl[6:5] == 2'b01) begin
        bus.alu_ps_compd = 1'b1;
        bus.alu_ps_az = (ax == ay);
        bus.alu_ps_an = ($signed(ax) < $signed(ay));
      end else begin
        sum = {1'b0, ax} + {1'b0, ay} + ((a_ctl[4:3] == 2'b01) ? {16'b0, a_ctl[0]} : 17'b0);
        ov  = (ax[15] == ay[15]) && (sum[15] != ax[15]);
        alu_res = sum[15:0];
        if (ov && a_ctl[1]) alu_res = ax[15] ? 16'h8000 : 16'h7fff;
        bus.alu_ps_ac = sum[16];
        bus.alu_ps_av = ov;
        bus.alu_ps_az = (alu_res == 16'h0);
        bus.alu_ps_an = alu_res[15];
      end
    end
  end

  // Monitor: compare controls whenever ps_alu_en is up, and status two
  // edges after each issue.
  logic [1:0] pipe = 2'b00;
  always @(negedge clk_exe) begin
    if (reset) begin
      ctrl_q.delete(); stat_q.delete(); op_q.delete();
      pipe = 2'b00;
    end else begin
      if (pipe[1]) begin
        if (stat_q.size() == 0) chk("status_unexpected", 32'h1, 32'h0);
        else chk("astat_cacc", {19'b0, bus.ps_astat, bus.ps_cacc}, {19'b0, stat_q.pop_front()});
      end
      pipe = {pipe[0], bus.ps_alu_en};
      if (bus.ps_alu_en) begin
        if (ctrl_q.size() == 0) chk("issue_unexpected", 32'h1, 32'h0);
        else chk("alu_ctrl", {24'b0, bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc,
                              bus.ps_alu_sat, bus.ps_alu_ci}, {24'b0, ctrl_q.pop_front()});
      end
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [1:0] unit,
                                     input logic lg, input logic [1:0] hc, input logic [2:0] sc);
    logic [31:0] w;
    w = 32'h0;
    w[31:28] = cond; w[25:24] = unit; w[22] = lg; w[21:20] = hc; w[19:17] = sc;
    return w;
  endfunction

  // Present an instruction until accepted; compare stall count and cond.
  task automatic send(input logic [31:0] ins, input logic sat, input logic [15:0] x, input logic [15:0] y,
                      input int exp_stall, input logic exp_ct, input logic exp_iss,
                      input logic exp_ci, input logic [4:0] exp_astat, input logic [7:0] exp_cacc);
    int n;
    logic ok;
    n = 0; ok = 1'b1;
    bus.ps_instr = ins; bus.ps_instr_vld = 1'b1; bus.ps_mode_sat = sat;
    forever begin
      @(negedge clk_exe);
      if (!bus.ps_instr_stall) break;
      n++;
      if (n > 8) begin ok = 1'b0; break; end
    end
    chk("stall_cycles", n, exp_stall);
    chk("cond_true", {31'b0, bus.ps_cond_true}, {31'b0, exp_ct});
    if (ok && exp_iss) begin
      ctrl_q.push_back({ins[22], ins[21:20], ins[19:17], sat, exp_ci});
      stat_q.push_back({exp_astat, exp_cacc});
      op_q.push_back({x, y});
    end
    @(posedge clk_exe); #1;
    bus.ps_instr_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_exe);
    #1;
  endtask

  // Hold ps_astat_clr across the capture edge of an op issued at the last edge.
  task automatic clr_at_capture();
    @(posedge clk_exe); #1 bus.ps_astat_clr = 1'b1;
    @(posedge clk_exe); #1 bus.ps_astat_clr = 1'b0;
  endtask

  localparam logic [31:0] ADD  = 32'h0;
  localparam logic [31:0] ADDC = 32'h0004_0000;  // sc = 010
  localparam logic [31:0] COMP = 32'h0010_0000;  // hc = 01

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.ps_instr = 32'h0; bus.ps_instr_vld = 1'b0;
    bus.ps_mode_sat = 1'b0; bus.ps_astat_clr = 1'b0;
    repeat (3) @(posedge clk_exe);
    #1;
    chk("reset_ctrl", {24'b0, bus.ps_alu_en, bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc,
                       bus.ps_alu_sat, bus.ps_alu_ci}, 32'h0);
    chk("reset_status", {19'b0, bus.ps_astat, bus.ps_cacc}, 32'h0);
    chk("reset_stall", {31'b0, bus.ps_instr_stall}, 32'h0);
    @(negedge clk_exe); reset = 1'b0;
    idle(2);
    chk("idle_status", {18'b0, bus.ps_alu_en, bus.ps_astat, bus.ps_cacc}, 32'h0);

    // Reset while an op is in flight: strobe drops at once, flags are lost.
    send(ADD, 1'b0, 16'h7fff, 16'h0001, 0, 1'b1, 1'b1, 1'b0, 5'b11010, 8'h00);
    @(negedge clk_exe); #1 reset = 1'b1;
    #1 chk("reset_mid_en", {31'b0, bus.ps_alu_en}, 32'h0);
    idle(3);
    @(negedge clk_exe); reset = 1'b0;
    idle(3);
    chk("reset_mid_astat", {19'b0, bus.ps_astat, bus.ps_cacc}, 32'h0);

    // Overflow without/with saturation, then carry-out feeding ADDC.
    send(ADD,  1'b0, 16'h7fff, 16'h0001, 0, 1'b1, 1'b1, 1'b0, 5'b11010, 8'h00);
    send(ADD,  1'b1, 16'h7fff, 16'h0001, 0, 1'b1, 1'b1, 1'b0, 5'b11000, 8'h00);
    send(ADD,  1'b0, 16'hffff, 16'h0001, 0, 1'b1, 1'b1, 1'b0, 5'b10101, 8'h00);
    send(ADDC, 1'b0, 16'h0001, 16'h0001, 2, 1'b1, 1'b1, 1'b1, 5'b10000, 8'h00);
    @(posedge clk_exe); #1;
    chk("addc_result", {16'b0, alu_res}, 32'h3);
    idle(3);

    // Compare history, then clear.
    send(COMP, 1'b0, 16'd5, 16'd3, 0, 1'b1, 1'b1, 1'b0, 5'b10000, 8'h80);
    send(COMP, 1'b0, 16'd3, 16'd5, 0, 1'b1, 1'b1, 1'b0, 5'b10010, 8'h40);
    send(COMP, 1'b0, 16'd4, 16'd4, 0, 1'b1, 1'b1, 1'b0, 5'b10001, 8'h20);
    idle(3);
    bus.ps_astat_clr = 1'b1; idle(1); bus.ps_astat_clr = 1'b0;
    chk("astat_clr", {19'b0, bus.ps_astat, bus.ps_cacc}, {19'b0, 5'b00001, 8'h00});

    // Clear coinciding with a capture: capture wins.
    send(COMP, 1'b0, 16'd5, 16'd3, 0, 1'b1, 1'b1, 1'b0, 5'b00000, 8'h80);
    idle(3);
    send(COMP, 1'b0, 16'd6, 16'd1, 0, 1'b1, 1'b1, 1'b0, 5'b00000, 8'h80);
    clr_at_capture();
    idle(2);
    send(ADD, 1'b0, 16'h7fff, 16'h0001, 0, 1'b1, 1'b1, 1'b0, 5'b11010, 8'h00);
    clr_at_capture();
    idle(2);

    // Consumed instructions: false conditions and a non-ALU unit.
    send(mk(4'h1, 2'b00, 1'b0, 2'b00, 3'b000), 1'b0, 16'h0, 16'h0, 0, 1'b0, 1'b0, 1'b0, 5'b0, 8'h0);
    chk("eq_false_en", {31'b0, bus.ps_alu_en}, 32'h0);
    send(mk(4'hF, 2'b00, 1'b0, 2'b00, 3'b000), 1'b0, 16'h0, 16'h0, 0, 1'b0, 1'b0, 1'b0, 5'b0, 8'h0);
    chk("never_en", {31'b0, bus.ps_alu_en}, 32'h0);
    send(mk(4'h0, 2'b01, 1'b0, 2'b00, 3'b000), 1'b0, 16'h0, 16'h0, 0, 1'b1, 1'b0, 1'b0, 5'b0, 8'h0);
    chk("other_unit_en", {31'b0, bus.ps_alu_en}, 32'h0);
    idle(3);
    chk("consumed_astat", {19'b0, bus.ps_astat, bus.ps_cacc}, {19'b0, 5'b11010, 8'h00});
    send(mk(4'h2, 2'b00, 1'b0, 2'b00, 3'b000), 1'b0, 16'h0, 16'h0, 0, 1'b1, 1'b1, 1'b0, 5'b10001, 8'h00);
    idle(3);

    // Five independent ADDs back to back; the fifth sees AC from the second.
    send(ADD, 1'b0, 16'h0001, 16'h0002, 0, 1'b1, 1'b1, 1'b0, 5'b10000, 8'h00);
    send(ADD, 1'b0, 16'h8000, 16'h8000, 0, 1'b1, 1'b1, 1'b0, 5'b11101, 8'h00);
    send(ADD, 1'b0, 16'hfffe, 16'h0001, 0, 1'b1, 1'b1, 1'b0, 5'b10010, 8'h00);
    send(ADD, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 1'b1, 1'b0, 5'b10001, 8'h00);
    send(ADD, 1'b0, 16'h7fff, 16'h7fff, 0, 1'b1, 1'b1, 1'b1, 5'b11010, 8'h00);
    idle(5);

    chk("scoreboard_drained", ctrl_q.size() + stat_q.size() + op_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps_alu_ctrl.md
# ps_alu_ctrl

Program-sequencer-side controller for the ALU compute interface. It decodes compute instructions addressed to the ALU and drives the registered `ps_alu_*` control bundle. It captures the returned flags (`alu_ps_az/an/ac/av/compd`) into the arithmetic status register (ASTAT) and evaluates instruction condition codes against that register. It stalls the sequencer whenever an instruction depends on flags that are still in flight.

## Interface
- `DATA_WIDTH`, 16: ALU datapath width. The ALU interface parameter is passed through; the control logic itself is width-independent.
- `CACC_WIDTH`, 8: depth of the compare-accumulator history.
- `clk_exe`  in  1: execute clock; every register in the block is clocked on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `ps_instr`  in  32: instruction word. Fields: [31:28] cond, [25:24] unit (00 = ALU), [22] log, [21:20] hc, [19:17] sc. All other bits are ignored.
- `ps_instr_vld`  in  1: `ps_instr` is valid this cycle.
- `ps_mode_sat`  in  1: saturation mode bit from MODE1, sampled at issue.
- `ps_astat_clr`  in  1: clears the AVS bit and CACC.
- `alu_ps_az`, `alu_ps_an`, `alu_ps_ac`, `alu_ps_av`, `alu_ps_compd`  in  1 each: flags returned by the ALU.
- `ps_alu_en`  out  1: ALU operation strobe, registered.
- `ps_alu_log` (1), `ps_alu_hc` (2), `ps_alu_sc` (3), `ps_alu_sat` (1), `ps_alu_ci` (1)  out: ALU control fields, registered.
- `ps_instr_stall`  out  1: combinational. When high, the current instruction is not accepted and the sequencer must hold it.
- `ps_astat`  out  5: {AVS, AV, AC, AN, AZ}.
- `ps_cacc`  out  CACC_WIDTH: compare accumulator.
- `ps_cond_true`  out  1: combinational result of evaluating the condition of the current instruction.

## Operation
- Accept: `ps_instr_vld & ~ps_instr_stall`. An accepted instruction with unit=00 and `ps_cond_true` is issued to the ALU.
  - All other accepted instructions are consumed with no ALU effect and no ASTAT change.
- Issue, registered at the accepting edge:
  - `ps_alu_en` = 1.
  - `log`, `hc`, `sc` are copied from the instruction fields.
  - `ps_alu_sat` = `ps_mode_sat`.
  - `ps_alu_ci` = ASTAT.AC.
- On cycles with no issue, `ps_alu_en` = 0. The other control outputs hold their last issued values.
- Condition codes (cond field):
  - 0000 always; 0001 AZ; 0010 ~AZ; 0011 AN; 0100 ~AN; 0101 AN|AZ; 0110 ~AN&~AZ.
  - 0111 AC; 1000 ~AC; 1001 AV; 1010 ~AV; 1011 CACC[MSB]; 1111 never.
  - All other codes evaluate false.
- Flag dependency: an instruction is flag-dependent if either:
  - cond != 0000, or
  - it is an ALU carry op (log=0, hc=00, sc[2:1]=01).
- In-flight tracking uses a two-stage valid pipe. s1 is set at the issue edge; s2 is s1 delayed by one edge.
- Stall: `ps_instr_stall = ps_instr_vld & flag_dependent & (s1 | s2)`.
  - Independent instructions issue back-to-back every cycle.
- Capture, at the edge that ends an s2 cycle:
  - AZ, AN, AC, AV <= the ALU flags.
  - AVS <= AVS | AV.
  - If `alu_ps_compd`: CACC <= {~an & ~az, CACC[MSB:1]}, i.e. the newest rx>ry result enters at the MSB.
- `ps_astat_clr` clears AVS and CACC to 0.
  - If a capture in the same cycle sets AVS, the set wins. A COMP capture in that cycle loads {gt, 0...}.
- Reset: all outputs and internal state are 0 (ASTAT = 0, CACC = 0, s1 = s2 = 0, `ps_alu_en` = 0). A reset mid-operation discards in-flight flags.

## Timing
- Edge E0: instruction accepted. Control outputs are valid from E0 to E1.
- Edge E1: the ALU latches the operands and controls.
- Between E1 and E2: the ALU flags are valid (combinational from the ALU).
- Edge E2: ASTAT and CACC are updated. `ps_astat` shows the new value after E2.
- Issue-to-status latency: 2 cycles.
- A dependent instruction presented in the cycle right after an issue stalls for 2 cycles. It is accepted at the edge after the flags are captured, so its condition or `ci` uses the updated ASTAT.
- `ps_cond_true` and `ps_instr_stall` are purely combinational from the registered state and `ps_instr`. They have no dependence on the ALU flag inputs.

## Test plan
Benches instantiate this block with `alu`.
- Reset, then idle: all outputs are 0. Hold `reset`=1 mid-issue: `ps_alu_en` drops to 0 immediately and ASTAT stays 0.
- ADD with sat=0, x=16'h7fff, y=16'h0001: two edges after issue, `ps_astat` = 5'b11010 (AVS, AV, AN set). Then issue ADD with sat=1 on the same data: AV=1, AN=0, AVS stays 1.
- ADD x=16'hffff, y=16'h0001 (AC=1, AZ=1), immediately followed by ADDC x=1, y=1:
  - `ps_instr_stall`=1 for 2 cycles.
  - ADDC is then issued with `ps_alu_ci`=1 and produces result 3.
- Three COMPs with (5,3), (3,5), (4,4), then `ps_astat_clr`:
  - `ps_cacc` = 8'h80, then 8'h40, then 8'h20.
  - After the clear, `ps_cacc` = 0 and AVS = 0.
- Issue cond=0001 (EQ) with AZ=0: the instruction is consumed, `ps_alu_en` stays 0 and ASTAT is unchanged. Issue cond=1111: the same result.
- Five back-to-back independent ADDs: `ps_alu_en`=1 for 5 consecutive cycles with no stall. ASTAT reflects each result in order, 2 cycles later.
